// File: rtl/logic_axi4_lite_bus_write_arbiter.sv
// Round-robin arbiter for the shared AXI4-Lite write path (AW/W/B).
// One master owns the path from grant until its B handshake, or until the
// response watchdog gives up on a slave that never answers.
module logic_axi4_lite_bus_write_arbiter #(
  parameter int MASTERS       = 2,
  parameter int TIMEOUT       = 256,
  parameter int INDEX_WIDTH   = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  parameter int COUNTER_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [MASTERS-1:0]     request,
  input  logic                   aw_handshake,
  input  logic                   w_handshake,
  input  logic                   b_handshake,
  output logic [MASTERS-1:0]     grant,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_RESPONSE = 2'd2
  } state_t;

  // Last counter value before the watchdog fires; irrelevant when disabled.
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST   =
    COUNTER_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX = INDEX_WIDTH'(MASTERS - 1);

  state_t                   state_q;
  logic [MASTERS-1:0]       grant_q;
  logic                     grant_valid_q;
  logic [INDEX_WIDTH-1:0]   grant_index_q;
  logic                     timeout_q;
  logic [INDEX_WIDTH-1:0]   ptr_q;
  logic                     aw_done_q;
  logic                     w_done_q;
  logic [COUNTER_WIDTH-1:0] counter_q;

  logic                     pick_found_d;
  logic [INDEX_WIDTH-1:0]   pick_index_d;
  logic [MASTERS-1:0]       pick_onehot_d;
  logic [INDEX_WIDTH-1:0]   ptr_next_d;
  logic                     addr_data_done_d;
  logic                     wd_expire_d;

  // Circular search for the first requester at or above the priority pointer.
  always_comb begin
    int cand;
    cand         = 0;
    pick_found_d = 1'b0;
    pick_index_d = '0;
    for (int k = 0; k < MASTERS; k++) begin
      cand = (int'(ptr_q) + k) % MASTERS;
      if (!pick_found_d && request[INDEX_WIDTH'(cand)]) begin
        pick_found_d = 1'b1;
        pick_index_d = INDEX_WIDTH'(cand);
      end
    end
  end

  // One-hot decode of the selected master, registered as the grant.
  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_onehot
      assign pick_onehot_d[gi] = (pick_index_d == INDEX_WIDTH'(gi));
    end
  endgenerate

  // After a release the master just served drops to lowest priority.
  assign ptr_next_d = (grant_index_q == LAST_INDEX) ? '0
                                                   : grant_index_q + 1'b1;

  // Both address and data phases finished, counting a handshake seen this cycle.
  assign addr_data_done_d = (aw_done_q | aw_handshake) & (w_done_q | w_handshake);

  // Watchdog fires on the last allowed response cycle with no B handshake.
  assign wd_expire_d = (TIMEOUT > 0) && (counter_q == CNT_LAST) && !b_handshake;

  // Arbitration state machine with registered grant, index and timeout pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      counter_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Handshake inputs have no meaning until someone is granted.
          if (pick_found_d) begin
            state_q       <= ST_ACTIVE;
            grant_q       <= pick_onehot_d;
            grant_valid_q <= 1'b1;
            grant_index_q <= pick_index_d;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          // The grant is held even if request drops: valid cannot retract.
          if (addr_data_done_d) begin
            state_q   <= ST_RESPONSE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            counter_q <= '0;
          end else begin
            if (aw_handshake) aw_done_q <= 1'b1;
            if (w_handshake)  w_done_q  <= 1'b1;
          end
        end

        ST_RESPONSE: begin
          if (b_handshake || wd_expire_d) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= ptr_next_d;
            timeout_q     <= wd_expire_d;
          end else if (TIMEOUT > 0) begin
            counter_q <= counter_q + 1'b1;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;
  assign timeout     = timeout_q;

  // At most one master may drive the write path.
  a_grant_onehot0 : assert property (@(posedge aclk) disable iff (areset)
    $onehot0(grant_q));

  // grant_valid is exactly the OR of the grant vector.
  a_valid_matches : assert property (@(posedge aclk) disable iff (areset)
    grant_valid_q == (|grant_q));

  // The binary index names the granted master whenever a grant exists.
  a_index_matches : assert property (@(posedge aclk) disable iff (areset)
    grant_valid_q |-> grant_q[grant_index_q]);

  // A timeout pulse always coincides with the released grant.
  a_timeout_release : assert property (@(posedge aclk) disable iff (areset)
    timeout_q |-> !grant_valid_q);

  // A grant only exists outside IDLE.
  a_grant_state : assert property (@(posedge aclk) disable iff (areset)
    grant_valid_q == (state_q != ST_IDLE));

endmodule

// File: tb/tb_logic_axi4_lite_bus_write_arbiter.sv
// Scoreboard bench for the write arbiter: stimulus pushes expected grant and
// release events, a negedge monitor pops and compares them as they occur.
module tb_logic_axi4_lite_bus_write_arbiter;

  localparam int M  = 4;
  localparam int TO = 8;

  localparam int EV_GRANT    = 0;
  localparam int EV_RELEASE  = 1;
  localparam int EV_CHANGE   = 2;
  localparam int EV_STRAY_TO = 3;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    bit to;
  } ev_t;

  logic         aclk    = 1'b0;
  logic         areset  = 1'b1;
  logic [M-1:0] request = '0;
  logic         aw_hs   = 1'b0;
  logic         w_hs    = 1'b0;
  logic         b_hs    = 1'b0;
  logic [M-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_index;
  logic         timeout;

  logic_axi4_lite_bus_write_arbiter #(
    .MASTERS(M),
    .TIMEOUT(TO)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .request     (request),
    .aw_handshake(aw_hs),
    .w_handshake (w_hs),
    .b_handshake (b_hs),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_index (grant_index),
    .timeout     (timeout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  bit   mon_en = 1'b0;
  logic         prev_gv    = 1'b0;
  logic [M-1:0] prev_grant = '0;
  logic [1:0]   prev_idx   = '0;

  // Monitor: classify what the DUT did this cycle and match it to the queue.
  always @(negedge aclk) begin
    ev_t          got;
    ev_t          e;
    bit           have;
    logic [M-1:0] exp_grant;
    if (mon_en) begin
      have     = 1'b1;
      got.kind = EV_GRANT;
      if (grant_valid && !prev_gv)                             got.kind = EV_GRANT;
      else if (!grant_valid && prev_gv)                        got.kind = EV_RELEASE;
      else if (grant != prev_grant || grant_index != prev_idx) got.kind = EV_CHANGE;
      else if (timeout)                                        got.kind = EV_STRAY_TO;
      else                                                     have = 1'b0;
      got.idx = int'(grant_index);
      got.cyc = cyc;
      got.to  = timeout;
      if (have) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: actual kind=%0d idx=%0d cyc=%0d to=%0b grant=%b, required no event",
                   got.kind, got.idx, got.cyc, got.to, grant);
        end else begin
          e = exp_q.pop_front();
          exp_grant = '0;
          if (e.kind == EV_GRANT) exp_grant = 4'b0001 << e.idx;
          if (got.kind != e.kind || got.idx != e.idx || got.cyc != e.cyc ||
              got.to != e.to || grant != exp_grant) begin
            n_bad++;
            $display("FAIL event: actual kind=%0d idx=%0d cyc=%0d to=%0b grant=%b, required kind=%0d idx=%0d cyc=%0d to=%0b grant=%b",
                     got.kind, got.idx, got.cyc, got.to, grant,
                     e.kind, e.idx, e.cyc, e.to, exp_grant);
          end
        end
      end
      prev_gv    = grant_valid;
      prev_grant = grant;
      prev_idx   = grant_index;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // One write transaction, called at a negedge with the DUT idle. Offsets
  // count negedges from the grant cycle; negative offsets mean "never".
  // b_off/rst_off count from the first RESPONSE cycle.
  task automatic txn(input logic [M-1:0] req, input int idx,
                     input int aw_off, input int w_off, input int w2_off,
                     input int b_off, input int rst_off);
    int c, m, e_cyc, r, last_t;
    bit to;
    c = cyc;
    request = req;
    m = (aw_off > w_off) ? aw_off : w_off;
    e_cyc = c + 2 + m;
    to = 1'b0;
    if (rst_off >= 0)    r = e_cyc + rst_off + 1;
    else if (b_off >= 0) r = e_cyc + b_off + 1;
    else begin
      r  = e_cyc + TO;
      to = 1'b1;
    end
    exp_q.push_back('{EV_GRANT, idx, c + 1, 1'b0});
    exp_q.push_back('{EV_RELEASE, (rst_off >= 0) ? 0 : idx, r, to});
    last_t = r - c - 1;
    for (int t = 0; t <= last_t; t++) begin
      @(negedge aclk);
      aw_hs  = (t == aw_off);
      w_hs   = (t == w_off) || (t == w2_off);
      b_hs   = (b_off >= 0) && (t == m + 1 + b_off);
      areset = (rst_off >= 0) && (t == m + 1 + rst_off);
    end
    $display("txn req=%b expect master %0d grant@%0d release@%0d timeout=%0b reset=%0b",
             req, idx, c + 1, r, to, rst_off >= 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: actual sim time exhausted, required $finish");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk("reset_grant", int'(grant), 0);
    chk("reset_grant_valid", int'(grant_valid), 0);
    chk("reset_grant_index", int'(grant_index), 0);
    chk("reset_timeout", int'(timeout), 0);
    areset = 1'b0;
    mon_en = 1'b1;

    // Single requester: AW+W together, B two cycles into RESPONSE.
    txn(4'b0100, 2, 1, 1, -1, 2, -1);
    // Pointer at 3: wrap past 3 to 0, then pointer 1 selects master 1.
    txn(4'b0011, 0, 0, 0, -1, 0, -1);
    txn(4'b0011, 1, 0, 0, -1, 1, -1);
    // Split handshakes with a duplicate W, no B: watchdog reveals RESPONSE entry.
    txn(4'b1000, 3, 3, 0, 1, -1, -1);
    // B on the eighth RESPONSE cycle: normal completion, no timeout pulse.
    txn(4'b0010, 1, 0, 0, -1, 7, -1);
    // Reset in RESPONSE with master 3 granted.
    txn(4'b1000, 3, 0, 1, -1, -1, 2);
    chk("midreset_grant_index", int'(grant_index), 0);
    chk("midreset_timeout", int'(timeout), 0);
    chk("midreset_grant", int'(grant), 0);
    // Pointer must be back at 0.
    txn(4'b1001, 0, 1, 0, -1, 0, -1);

    // Fresh reset, then all four request continuously.
    areset = 1'b1;
    request = '0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      txn(4'b1111, k % 4, k % 2, (k / 2) % 2, -1, k % 3, -1);
    end
    request = '0;
    repeat (4) @(negedge aclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_grant_valid", int'(grant_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_axi4_lite_bus_write_arbiter.md
Name: logic_axi4_lite_bus_write_arbiter

Overview:
- Round-robin arbiter that shares the single write path (AW/W/B) of the AXI4-Lite multi-master bus between MASTERS requesters.
- Grants exactly one master at a time and holds the grant for a whole write transaction: AW handshake, W handshake, then B handshake.
- Sits between the slave-side request inputs and the bus write multiplexers. Its grant drives the mux selects and the ready/valid gating.
- Includes a response watchdog, so a hung slave cannot lock the bus.

Parameters:
- MASTERS, 2, number of requesting masters (>=1).
- TIMEOUT, 256, max cycles in RESPONSE before forced release. 0 disables the watchdog.
- INDEX_WIDTH, (MASTERS > 1) ? $clog2(MASTERS) : 1, width of grant_index (derived).
- COUNTER_WIDTH, (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1, watchdog counter width (derived).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  reset, synchronous, active-high.
- request  input  MASTERS  bit i = master i awvalid (pending write).
- aw_handshake  input  1  awvalid&&awready seen on the granted (muxed) downstream AW channel.
- w_handshake  input  1  wvalid&&wready seen on the muxed W channel.
- b_handshake  input  1  bvalid&&bready seen on the muxed B channel.
- grant  output  MASTERS  one-hot grant; all zero when idle.
- grant_valid  output  1  OR of grant.
- grant_index  output  INDEX_WIDTH  binary index of the granted master; holds its last value when idle.
- timeout  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (areset=1 at a rising edge):
  - state=IDLE, grant=0, grant_valid=0, grant_index=0, timeout=0.
  - Priority pointer=0 (master 0 highest), aw_done=0, w_done=0, counter=0.
  - Reset mid-transaction aborts it immediately: no timeout pulse, and the pointer returns to 0.
- States: IDLE, ACTIVE, RESPONSE.
- IDLE:
  - If request!=0, select the first set bit searching circularly from the pointer upward (wrapping MASTERS-1 -> 0).
  - Register grant/grant_index and enter ACTIVE next cycle. Grant latency is 1 cycle from request sampled high.
  - Handshake inputs are ignored in IDLE.
- ACTIVE:
  - aw_handshake sets aw_done; w_handshake sets w_done. Both may occur in the same cycle or in either order.
  - When (aw_done|aw_handshake)&&(w_done|w_handshake), go to RESPONSE next cycle and clear both flags.
  - Repeated handshakes after a flag is set are ignored.
  - The granted master dropping request does not release the grant: AXI valid cannot legally retract.
  - No watchdog runs in ACTIVE; AW/W completion is the master's responsibility.
- RESPONSE:
  - On b_handshake:
    - grant=0 and state=IDLE next cycle.
    - pointer=(granted index+1) mod MASTERS.
  - IDLE always spends at least one cycle before the next grant, giving a one-cycle bubble between transactions.
  - Watchdog (TIMEOUT>0):
    - The counter clears on entry to RESPONSE and increments each RESPONSE cycle without b_handshake.
    - When the counter reaches TIMEOUT-1 with no b_handshake, pulse timeout for one cycle on the next cycle.
    - That same cycle, release the grant, rotate the pointer as for a normal completion, and return to IDLE.
    - If b_handshake coincides with the expiry cycle, it is a normal completion and no timeout pulse is issued.
- Fairness: a continuously requesting master waits at most MASTERS-1 transactions.
- MASTERS=1: grant_index is constantly 0 and grant[0] follows the state machine.
- grant is always one-hot or zero (assertion required).
- grant_index and grant change only on IDLE->ACTIVE and RESPONSE->IDLE transitions.

Test Plan:
- Single requester: MASTERS=4, request=4'b0100 from reset; AW and W in the same cycle 3; B in cycle 6 -> grant=4'b0100 and grant_index=2 from cycle 2; RESPONSE from cycle 4; grant=0 in cycle 7.
- Round robin: request=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with one idle cycle between each.
- Wrap and skip: pointer=3 (after master 2 completes), request=4'b0011 -> master 0 granted, pointer becomes 1 after it completes.
- Split handshakes: w_handshake in cycle N, aw_handshake in cycle N+3, duplicate w_handshake in N+1 -> RESPONSE entered at N+4 only.
- Watchdog: TIMEOUT=8, no b_handshake -> timeout=1 exactly one cycle after the 8th RESPONSE cycle, grant=0 that same cycle. With b_handshake on the 8th RESPONSE cycle -> no timeout pulse.
- Reset mid-RESPONSE with master 3 granted -> next cycle grant=0, grant_index=0, timeout=0; request=4'b1001 then grants master 0.
